// File: rtl/mono_conf_pkg.sv
// Shared state encoding and default timing for the MONOPIX configuration-chain writer.
package mono_conf_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RSTP,
      ST_FETCH,
      ST_LOW,
      ST_HIGH,
      ST_LOADD,
      ST_LOADP,
      ST_DONE
   } conf_state_t;

   localparam int DEF_CLK_DIV   = 4;
   localparam int DEF_LD_CYCLES = 4;
   localparam int DEF_SIZE_W    = 16;
   localparam int CNT_W         = 16;

   // After the shift (or an empty shift) LdDAC goes before LdPix.
   function automatic conf_state_t loadEntry(input logic ldDac, input logic ldPix);
      if (ldDac)
         return ST_LOADD;
      else if (ldPix)
         return ST_LOADP;
      else
         return ST_DONE;
   endfunction

endpackage

// File: rtl/mono_conf_clkgen.sv
// Half-period / pulse-width counter; phase selects between two lengths within one state.
module mono_conf_clkgen
   import mono_conf_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             restart_i,
   input  logic [CNT_W-1:0] len0_i,
   input  logic [CNT_W-1:0] len1_i,
   output logic             tick_o,
   output logic             phase_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d, len;
   logic             phase_q, phase_d;

   assign len     = phase_q ? len1_i : len0_i;
   assign tick_o  = (cnt_q == len - 1'b1);
   assign phase_o = phase_q;

   // A state change in the parent always restarts at phase 0, count 0.
   always_comb begin
      cnt_d   = cnt_q + 1'b1;
      phase_d = phase_q;
      if (restart_i) begin
         cnt_d   = '0;
         phase_d = 1'b0;
      end else if (tick_o) begin
         cnt_d   = '0;
         phase_d = ~phase_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q   <= '0;
         phase_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
      end
   end

endmodule

// File: rtl/mono_conf_driver.sv
// MONOPIX configuration writer: shifts command bits out on Clk_Conf/SR_In, captures SR_out
// readback, then issues LdDAC/LdPix (or a bare SR_RST pulse).
module mono_conf_driver
   import mono_conf_pkg::*;
#(
   parameter int CLK_DIV   = DEF_CLK_DIV,
   parameter int LD_CYCLES = DEF_LD_CYCLES,
   parameter int SIZE_W    = DEF_SIZE_W
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              cmd_start_i,
   input  logic [SIZE_W-1:0] cmd_size_i,
   input  logic              cmd_ld_dac_i,
   input  logic              cmd_ld_pix_i,
   input  logic              cmd_sr_rst_i,
   input  logic [7:0]        din_i,
   input  logic              din_valid_i,
   output logic              din_ready_o,
   output logic [7:0]        dout_o,
   output logic              dout_valid_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              Clk_Conf_o,
   output logic              SR_In_o,
   output logic              SR_EN_o,
   output logic              LdDAC_o,
   output logic              LdPix_o,
   output logic              SR_RST_o,
   input  logic              SR_out_i
);

   localparam logic [CNT_W-1:0] DIV_LEN = CNT_W'(CLK_DIV);
   localparam logic [CNT_W-1:0] LD_LEN  = CNT_W'(LD_CYCLES);

   conf_state_t       state_q, state_d;
   logic [SIZE_W-1:0] size_q, size_d, bit_cnt_q, bit_cnt_d, bit_nxt;
   logic              ld_dac_q, ld_dac_d, ld_pix_q, ld_pix_d;
   logic [7:0]        tx_q, tx_d, rx_q, rx_d, dout_q, dout_d;
   logic              dout_valid_q, dout_valid_d;
   logic              tick, phase;
   logic [CNT_W-1:0]  len0;

   assign len0    = (state_q == ST_RSTP) ? LD_LEN : DIV_LEN;
   assign bit_nxt = bit_cnt_q + 1'b1;

   mono_conf_clkgen u_clkgen (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .restart_i (state_d != state_q),
      .len0_i    (len0),
      .len1_i    (LD_LEN),
      .tick_o    (tick),
      .phase_o   (phase)
   );

   // Bit position inside the current byte is bit_cnt[2:0], since bytes start on multiples of 8.
   always_comb begin
      state_d      = state_q;
      size_d       = size_q;
      bit_cnt_d    = bit_cnt_q;
      ld_dac_d     = ld_dac_q;
      ld_pix_d     = ld_pix_q;
      tx_d         = tx_q;
      rx_d         = rx_q;
      dout_d       = dout_q;
      dout_valid_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cmd_start_i) begin
               size_d    = cmd_size_i;
               ld_dac_d  = cmd_ld_dac_i;
               ld_pix_d  = cmd_ld_pix_i;
               bit_cnt_d = '0;
               if (cmd_sr_rst_i)
                  state_d = ST_RSTP;
               else if (cmd_size_i != '0)
                  state_d = ST_FETCH;
               else
                  state_d = loadEntry(cmd_ld_dac_i, cmd_ld_pix_i);
            end
         end
         ST_RSTP: if (tick) state_d = ST_DONE;
         ST_FETCH: begin
            if (din_valid_i) begin
               tx_d    = din_i;
               state_d = ST_LOW;
            end
         end
         ST_LOW: begin
            if (tick) begin
               rx_d = {rx_q[6:0], SR_out_i};
               if (bit_cnt_q[2:0] == 3'd7) begin
                  dout_d       = {rx_q[6:0], SR_out_i};
                  dout_valid_d = 1'b1;
               end
               state_d = ST_HIGH;
            end
         end
         ST_HIGH: begin
            if (tick) begin
               bit_cnt_d = bit_nxt;
               tx_d      = {tx_q[6:0], 1'b0};
               if (bit_nxt == size_q) begin
                  // A partial last byte is still sitting right-aligned in rx_q.
                  if (size_q[2:0] != 3'd0) begin
                     dout_d       = rx_q << (4'd8 - {1'b0, size_q[2:0]});
                     dout_valid_d = 1'b1;
                  end
                  state_d = loadEntry(ld_dac_q, ld_pix_q);
               end else if (bit_cnt_q[2:0] == 3'd7) begin
                  state_d = ST_FETCH;
               end else begin
                  state_d = ST_LOW;
               end
            end
         end
         ST_LOADD: if (tick && phase) state_d = ld_pix_q ? ST_LOADP : ST_DONE;
         ST_LOADP: if (tick && phase) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= ST_IDLE;
         size_q       <= '0;
         bit_cnt_q    <= '0;
         ld_dac_q     <= 1'b0;
         ld_pix_q     <= 1'b0;
         tx_q         <= '0;
         rx_q         <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         size_q       <= size_d;
         bit_cnt_q    <= bit_cnt_d;
         ld_dac_q     <= ld_dac_d;
         ld_pix_q     <= ld_pix_d;
         tx_q         <= tx_d;
         rx_q         <= rx_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
      end
   end

   // SR_In is held through HIGH so it is stable across the chip's rising-edge sample.
   assign din_ready_o  = (state_q == ST_FETCH);
   assign dout_o       = dout_q;
   assign dout_valid_o = dout_valid_q;
   assign busy_o       = (state_q != ST_IDLE);
   assign done_o       = (state_q == ST_DONE);
   assign Clk_Conf_o   = (state_q == ST_HIGH);
   assign SR_In_o      = ((state_q == ST_LOW) || (state_q == ST_HIGH)) && tx_q[7];
   assign SR_EN_o      = (state_q == ST_FETCH) || (state_q == ST_LOW) || (state_q == ST_HIGH);
   assign LdDAC_o      = (state_q == ST_LOADD) && phase;
   assign LdPix_o      = (state_q == ST_LOADP) && phase;
   assign SR_RST_o     = (state_q == ST_RSTP);

endmodule

// File: tb/tb_mono_conf_driver.sv
// Directed bench for mono_conf_driver with an 8-bit loopback chip model on SR_In/SR_out.
module tb_mono_conf_driver;

   typedef struct {
      logic [15:0] size;
      logic        ldDac;
      logic        ldPix;
      logic        srRst;
      logic [7:0]  din0;
      logic [7:0]  din1;
      logic [7:0]  chipPre;
      int          stall;
      logic        extraStart;
      int          expEdges;
      logic [15:0] expSeq;
      int          expDout;
      logic [7:0]  expD0;
      logic [7:0]  expD1;
      logic [7:0]  expChip;
      int          expDac;
      int          expPix;
      int          expRst;
      int          expAcc;
      int          expMinGap;
      int          expMaxGap;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst, cmdStart, cmdLdDac, cmdLdPix, cmdSrRst, dinValid;
   logic [15:0] cmdSize;
   logic [7:0]  din, dout;
   logic        dinReady, doutValid, busy, done, clkConf, srIn, srEn, ldDac, ldPix, srRst, srOut;

   int total = 0;
   int bad   = 0;

   // Monitor state, owned by the negedge process below.
   logic        clearMon = 1'b0;
   logic [7:0]  chipPreVal = 8'h00;
   logic [7:0]  chipQ;
   logic [15:0] srInLog;
   logic [7:0]  doutLog [0:3];
   logic        prevClkConf;
   int edgeCount, doneCount, doutCount, acceptCount, dacCycles, pixCycles, rstCycles, overlap;
   int minGap, maxGap, cyc, lastEdgeCyc, gap, stallHigh;

   vec_t vecs [6];

   mono_conf_driver #(.CLK_DIV(4), .LD_CYCLES(4), .SIZE_W(16)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .cmd_start_i  (cmdStart),
      .cmd_size_i   (cmdSize),
      .cmd_ld_dac_i (cmdLdDac),
      .cmd_ld_pix_i (cmdLdPix),
      .cmd_sr_rst_i (cmdSrRst),
      .din_i        (din),
      .din_valid_i  (dinValid),
      .din_ready_o  (dinReady),
      .dout_o       (dout),
      .dout_valid_o (doutValid),
      .busy_o       (busy),
      .done_o       (done),
      .Clk_Conf_o   (clkConf),
      .SR_In_o      (srIn),
      .SR_EN_o      (srEn),
      .LdDAC_o      (ldDac),
      .LdPix_o      (ldPix),
      .SR_RST_o     (srRst),
      .SR_out_i     (srOut)
   );

   always #5 clk = ~clk;

   assign srOut = chipQ[7];

   // Chip model and event counters, sampled mid-cycle.
   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (clearMon) begin
         chipQ       <= chipPreVal;
         srInLog     <= '0;
         prevClkConf <= 1'b0;
         edgeCount   <= 0;
         doneCount   <= 0;
         doutCount   <= 0;
         acceptCount <= 0;
         dacCycles   <= 0;
         pixCycles   <= 0;
         rstCycles   <= 0;
         overlap     <= 0;
         minGap      <= 0;
         maxGap      <= 0;
         lastEdgeCyc <= 0;
         for (int k = 0; k < 4; k++) doutLog[k] <= 8'h00;
      end else begin
         prevClkConf <= clkConf;
         if (clkConf === 1'b1 && prevClkConf === 1'b0) begin
            edgeCount <= edgeCount + 1;
            srInLog   <= {srInLog[14:0], srIn};
            chipQ     <= {chipQ[6:0], srIn};
            if (edgeCount > 0) begin
               gap = cyc - lastEdgeCyc;
               if (minGap == 0 || gap < minGap) minGap <= gap;
               if (gap > maxGap) maxGap <= gap;
            end
            lastEdgeCyc <= cyc;
         end
         if (done === 1'b1) doneCount <= doneCount + 1;
         if (doutValid === 1'b1) begin
            if (doutCount < 4) doutLog[doutCount] <= dout;
            doutCount <= doutCount + 1;
         end
         if (dinValid === 1'b1 && dinReady === 1'b1) acceptCount <= acceptCount + 1;
         if (ldDac === 1'b1) dacCycles <= dacCycles + 1;
         if (ldPix === 1'b1) pixCycles <= pixCycles + 1;
         if (srRst === 1'b1) rstCycles <= rstCycles + 1;
         if (ldDac === 1'b1 && ldPix === 1'b1) overlap <= overlap + 1;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic prepare(input logic [7:0] pre);
      chipPreVal = pre;
      clearMon   = 1'b1;
      stallHigh  = 0;
      @(posedge clk); #1;
      clearMon   = 1'b0;
   endtask

   function automatic logic [17:0] allOutputs();
      return {dinReady, dout, doutValid, busy, done, clkConf, srIn, srEn, ldDac, ldPix, srRst};
   endfunction

   task automatic applyStimulus(input vec_t v, output logic timedOut);
      int stallLeft;
      prepare(v.chipPre);
      cmdSize  = v.size;
      cmdLdDac = v.ldDac;
      cmdLdPix = v.ldPix;
      cmdSrRst = v.srRst;
      cmdStart = 1'b1;
      din      = v.din0;
      dinValid = 1'b1;
      @(posedge clk); #1;
      cmdStart  = 1'b0;
      stallLeft = v.stall;
      timedOut  = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         din = (acceptCount == 0) ? v.din0 : (acceptCount == 1) ? v.din1 : 8'h99;
         if (dinReady && acceptCount == 1 && stallLeft > 0) begin
            dinValid = 1'b0;
            stallLeft--;
            if (clkConf !== 1'b0) stallHigh++;
         end else begin
            dinValid = 1'b1;
         end
         if (v.extraStart && c == 2) begin
            cmdStart = 1'b1;
            cmdSize  = 16'd8;
            cmdLdDac = 1'b1;
            cmdSrRst = 1'b0;
         end else begin
            cmdStart = 1'b0;
         end
         @(posedge clk); #1;
         if (doneCount != 0) begin
            timedOut = 1'b0;
            break;
         end
      end
      cmdStart = 1'b0;
      dinValid = 1'b0;
      repeat (30) @(posedge clk);
      #1;
   endtask

   initial begin
      logic timedOut;
      vecs[0] = '{16'd8,  1'b1, 1'b0, 1'b0, 8'hA5, 8'h00, 8'h3C, 0,  1'b0,
                  8,  16'h00A5, 1, 8'h3C, 8'h00, 8'hA5, 4, 0, 0, 1, 8, 8};
      vecs[1] = '{16'd12, 1'b0, 1'b0, 1'b0, 8'hFF, 8'h0F, 8'h00, 0,  1'b0,
                  12, 16'h0FF0, 2, 8'h00, 8'hF0, 8'hF0, 0, 0, 0, 2, 8, 9};
      vecs[2] = '{16'd16, 1'b0, 1'b0, 1'b0, 8'h5A, 8'hC3, 8'h81, 20, 1'b0,
                  16, 16'h5AC3, 2, 8'h81, 8'h5A, 8'hC3, 0, 0, 0, 2, 8, 29};
      vecs[3] = '{16'd8,  1'b0, 1'b0, 1'b1, 8'h11, 8'h00, 8'h55, 0,  1'b1,
                  0,  16'h0000, 0, 8'h00, 8'h00, 8'h55, 0, 0, 4, 0, 0, 0};
      vecs[4] = '{16'd0,  1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h3C, 0,  1'b0,
                  0,  16'h0000, 0, 8'h00, 8'h00, 8'h3C, 0, 4, 0, 0, 0, 0};
      vecs[5] = '{16'd3,  1'b1, 1'b1, 1'b0, 8'hE0, 8'h00, 8'hA0, 0,  1'b0,
                  3,  16'h0007, 1, 8'hA0, 8'h00, 8'h07, 4, 4, 0, 1, 8, 8};

      rst = 1'b1; cmdStart = 1'b0; cmdSize = '0; cmdLdDac = 1'b0; cmdLdPix = 1'b0;
      cmdSrRst = 1'b0; din = '0; dinValid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset outputs", 32'(allOutputs()), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      checkOutput("idle outputs", 32'(allOutputs()), 32'd0);

      // Abort a 16-bit shift with reset once the fifth rising edge has been seen.
      prepare(8'h00);
      cmdSize = 16'd16; cmdLdDac = 1'b1; cmdStart = 1'b1; din = 8'hFF; dinValid = 1'b1;
      @(posedge clk); #1;
      cmdStart = 1'b0;
      timedOut = 1'b1;
      for (int c = 0; c < 500; c++) begin
         if (edgeCount >= 5) begin
            timedOut = 1'b0;
            break;
         end
         @(posedge clk); #1;
      end
      checkOutput("abort reach edge 5", 32'(timedOut), 32'd0);
      rst = 1'b1;
      @(posedge clk); #1;
      checkOutput("abort outputs", 32'(allOutputs()), 32'd0);
      checkOutput("abort busy", 32'(busy), 32'd0);
      rst = 1'b0; dinValid = 1'b0; cmdLdDac = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      checkOutput("abort no done", 32'(doneCount), 32'd0);
      checkOutput("abort edges", 32'(edgeCount), 32'd5);

      for (int i = 0; i < 6; i++) begin
         applyStimulus(vecs[i], timedOut);
         checkOutput($sformatf("v%0d timeout", i), 32'(timedOut), 32'd0);
         checkOutput($sformatf("v%0d edges", i), 32'(edgeCount), 32'(vecs[i].expEdges));
         checkOutput($sformatf("v%0d SR_In seq", i), 32'(srInLog), 32'(vecs[i].expSeq));
         checkOutput($sformatf("v%0d dout count", i), 32'(doutCount), 32'(vecs[i].expDout));
         checkOutput($sformatf("v%0d dout0", i), 32'(doutLog[0]), 32'(vecs[i].expD0));
         checkOutput($sformatf("v%0d dout1", i), 32'(doutLog[1]), 32'(vecs[i].expD1));
         checkOutput($sformatf("v%0d chip", i), 32'(chipQ), 32'(vecs[i].expChip));
         checkOutput($sformatf("v%0d LdDAC width", i), 32'(dacCycles), 32'(vecs[i].expDac));
         checkOutput($sformatf("v%0d LdPix width", i), 32'(pixCycles), 32'(vecs[i].expPix));
         checkOutput($sformatf("v%0d SR_RST width", i), 32'(rstCycles), 32'(vecs[i].expRst));
         checkOutput($sformatf("v%0d bytes taken", i), 32'(acceptCount), 32'(vecs[i].expAcc));
         checkOutput($sformatf("v%0d min gap", i), 32'(minGap), 32'(vecs[i].expMinGap));
         checkOutput($sformatf("v%0d max gap", i), 32'(maxGap), 32'(vecs[i].expMaxGap));
         checkOutput($sformatf("v%0d done pulses", i), 32'(doneCount), 32'd1);
         checkOutput($sformatf("v%0d load overlap", i), 32'(overlap), 32'd0);
         checkOutput($sformatf("v%0d stall clk high", i), 32'(stallHigh), 32'd0);
         checkOutput($sformatf("v%0d busy after", i), 32'(busy), 32'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
